fix_order_encoder: RTL and testbench
====================================

Name: fix_order_encoder

Overview:
Transmit-side FIX 4.2 serializer. It accepts one order request per handshake (New Single Order 35=D, Cancel/Replace 35=G, Cancel 35=F) and emits the complete tag=value byte stream, one byte per beat, on a valid/ready byte interface toward the session/MAC layer. It computes BodyLength (9) and CheckSum (10) in hardware. It is the outbound counterpart of the inbound FIX parser feeding the order book.

Parameters:
SOH_CHAR, 8'h01, field delimiter byte (8'h7C for readable debug logs).

Ports:
clk  in  1  clock
rst  in  1  reset
req_valid  in  1  order request valid
req_ready  out  1  encoder idle and can accept a request
req_type  in  2  2'b01=D new, 2'b10=G modify, 2'b11=F cancel, 2'b00=illegal
cl_ord_id  in  32  tag 11, 4 ASCII bytes, MSB byte first
orig_cl_ord_id  in  32  tag 41, 4 ASCII bytes, used for G and F only
symbol  in  48  tag 55, 6 ASCII bytes
side  in  8  tag 54, 1 ASCII byte
price  in  64  tag 44, 8 ASCII bytes, used for D and G only
quantity  in  64  tag 38, 8 ASCII bytes, used for D and G only
tx_data  out  8  serialized byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  downstream accepts byte
tx_sop  out  1  first byte of message ('8')
tx_eop  out  1  last byte of message (final SOH)
req_err  out  1  one-cycle pulse when an illegal req_type is dropped

Behaviour:
- Reset: rst is asynchronous and active-high; clock is clk. All outputs go to 0, except req_ready, which is 1 one cycle after rst deasserts. FSM goes to IDLE, checksum clears, and any partial message is abandoned with no completion.
- Accept when req_valid && req_ready. All fields are latched that cycle. req_ready drops the next cycle.
- If req_type==2'b00: no output is produced, req_err pulses the next cycle, and req_ready stays 1.
- Message order: "8=FIX.4.2"SOH, "9=NN"SOH, "35=x"SOH, "11="id SOH, ["41="orig SOH], "55="sym SOH, "54="side SOH, ["44="price SOH], ["38="qty SOH], "10=CCC"SOH.
- Bracketed fields are omitted per type: D omits 41; F omits 44 and 38.
- BodyLength: D=52, G=60, F=36. It is 2 ASCII decimal digits, computed from req_type at accept. It counts bytes from "35=" through the SOH before "10=".
- Total message bytes: D=74, G=82, F=58.
- Byte ordering: multi-byte fields are sent MSB byte first (e.g. symbol[47:40] first).
- FSM states:
  - IDLE: req_ready=1.
  - HDR: fixed 10 bytes "8=FIX.4.2"SOH.
  - BLEN: 5 bytes.
  - BODY: field index plus byte index counters; optional fields are skipped.
  - CKSUM: 7 bytes.
  - Transitions happen only on a transfer beat (tx_valid && tx_ready).
  - After the last CKSUM beat the FSM returns to IDLE; req_ready is 1 the next cycle.
- First byte: tx_valid is asserted the cycle after accept, with tx_sop=1 on that byte.
- tx interface: tx_data, tx_sop and tx_eop must stay stable while tx_valid && !tx_ready. With tx_ready held high, throughput is one byte per cycle with no bubbles inside a message.
- Checksum: 8-bit wrap-around sum of every transferred byte from '8' through the SOH preceding "10=".
  - It is converted to 3 ASCII digits on entry to CKSUM, with leading zeros (e.g. 7 -> "007").
  - The conversion uses compare/subtract against 200/100, then a 0..99 tens/ones split; no divider.
- Stalls: tx_ready low for any duration, including on the sop or eop byte, must not corrupt the sequence or the checksum.
- req_valid during an active message is ignored (req_ready=0).

Optional Feature:
FIX_ENC_SEQNUM_EN
- Defined: tag "34=NNNNNN"SOH (10 bytes) is inserted right after the 35 field. NNNNNN is a 6-digit BCD counter sent as ASCII.
  - The counter resets to 000001 and increments after each completed message, wrapping 999999 -> 000000.
  - BodyLength becomes D=62, G=70, F=46.
  - An abandoned message (reset) does not increment the counter.
- Undefined: no tag 34, no counter logic, and BodyLength as listed above.

Test Plan:
- D request: cl_ord_id="1234", symbol="AAPL  ", side="1", price="00150.25", quantity="00000100", tx_ready=1 -> 74 contiguous bytes.
  - Bytes 10-14 are "9=52"SOH.
  - No tag 41 appears.
  - tx_sop on byte 0, tx_eop on byte 73.
  - "10=CCC" matches the bench mod-256 sum.
- F request: orig_cl_ord_id="1234", cl_ord_id="1235" -> 58 bytes, "9=36", no tags 44/38, tag 41 before 55.
- G request with random tx_ready (50%) backpressure -> 82 bytes; the byte sequence is identical to the no-stall run, and data is held stable during stalls.
- req_type=2'b00 -> no tx_valid, req_err one pulse, req_ready remains 1; a following D request encodes normally.
- Async rst asserted at byte 30 of a D message -> tx_valid=0 immediately, req_ready=1 after release; the next D message is complete with a correct checksum.
- With FIX_ENC_SEQNUM_EN: three back-to-back D requests -> "34=000001", "34=000002", "34=000003", each with "9=62"; req_ready is 1 the cycle after each tx_eop beat.

Source files
------------

// File: rtl/fix_order_encoder.sv
// rtl/fix_order_encoder.sv - FIX 4.2 order serializer with hardware BodyLength and CheckSum
//
// Accepts one order request (35=D new, 35=G cancel/replace, 35=F cancel).
// Streams the complete tag=value message one byte per beat on a valid/ready byte interface.
// Tag 9 (BodyLength) and tag 10 (CheckSum) are generated while the message streams.
//
// Optional feature macro: FIX_ENC_SEQNUM_EN.
//   When defined, a 6-digit BCD MsgSeqNum field "34=NNNNNN"SOH is inserted right after tag 35.
//
// Parameters:
//   SOH_CHAR        field delimiter byte (8'h01; 8'h7C gives readable debug logs)
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   req_valid/ready request handshake; req_ready is high only while idle
//   req_type        01=D, 10=G, 11=F, 00=illegal (dropped, req_err pulses)
//   cl_ord_id       tag 11, 4 ASCII bytes
//   orig_cl_ord_id  tag 41, 4 ASCII bytes (G/F only)
//   symbol          tag 55, 6 ASCII bytes
//   side            tag 54, 1 ASCII byte
//   price           tag 44, 8 ASCII bytes (D/G only)
//   quantity        tag 38, 8 ASCII bytes (D/G only)
//   tx_data/valid   serialized byte stream, MSB byte of each field first
//   tx_ready        downstream accepts the byte
//   tx_sop/tx_eop   first byte ('8') / last byte (final SOH) of a message
//   req_err         one-cycle pulse after an illegal request is dropped
module fix_order_encoder #(
   parameter logic [7:0] SOH_CHAR = 8'h01
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_type,
   input  logic [31:0] cl_ord_id,
   input  logic [31:0] orig_cl_ord_id,
   input  logic [47:0] symbol,
   input  logic [7:0]  side,
   input  logic [63:0] price,
   input  logic [63:0] quantity,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        tx_sop,
   output logic        tx_eop,
   output logic        req_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_BLEN,
      S_BODY,
      S_CKSUM
   } state_t;

   localparam logic [1:0] TYPE_D = 2'b01;
   localparam logic [1:0] TYPE_G = 2'b10;

   // Body field order; the field counter walks upward and skips absent fields.
   localparam logic [2:0] FLD_35 = 3'd0;
   localparam logic [2:0] FLD_34 = 3'd1;
   localparam logic [2:0] FLD_11 = 3'd2;
   localparam logic [2:0] FLD_41 = 3'd3;
   localparam logic [2:0] FLD_55 = 3'd4;
   localparam logic [2:0] FLD_54 = 3'd5;
   localparam logic [2:0] FLD_44 = 3'd6;
   localparam logic [2:0] FLD_38 = 3'd7;

   localparam logic [79:0] HDR_STR = {"8=FIX.4.2", SOH_CHAR};

`ifdef FIX_ENC_SEQNUM_EN
   localparam bit          SEQ_EN = 1'b1;
   localparam logic [15:0] BLEN_D = "62";
   localparam logic [15:0] BLEN_G = "70";
   localparam logic [15:0] BLEN_F = "46";
`else
   localparam bit          SEQ_EN = 1'b0;
   localparam logic [15:0] BLEN_D = "52";
   localparam logic [15:0] BLEN_G = "60";
   localparam logic [15:0] BLEN_F = "36";
`endif

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [2:0]  fld_q, fld_d;
   logic        ready_q;
   logic [1:0]  typ_q;
   logic [31:0] id_q, orig_q;
   logic [47:0] sym_q;
   logic [7:0]  side_q;
   logic [63:0] px_q, qty_q;
   logic [15:0] blen_q;
   logic [7:0]  sum_q, sum_fin;
   logic [23:0] ck_q;
   logic        accept, beat;
   logic [7:0]  tag_hi, tag_lo, type_char;
   logic [3:0]  vlen, vidx, hsh;
   logic [2:0]  vsh;
   logic [63:0] fval;
   logic        nxt_found, fld_last;
   logic [2:0]  nxt_fld;
`ifdef FIX_ENC_SEQNUM_EN
   logic [23:0] seq_q;
`endif

   function automatic logic fld_present(input logic [2:0] f, input logic [1:0] t);
      logic p;
      p = 1'b1;
      if (f == FLD_34)
         p = SEQ_EN;
      else if (f == FLD_41)
         p = (t != TYPE_D);
      else if (f == FLD_44 || f == FLD_38)
         p = (t == TYPE_D || t == TYPE_G);
      return p;
   endfunction

   // Binary 0..255 to three ASCII digits by compare/subtract; no divider.
   function automatic logic [23:0] to_ascii3(input logic [7:0] s);
      logic [7:0] r, sub;
      logic [3:0] h, t;
      if (s >= 8'd200) begin
         h = 4'd2;
         r = s - 8'd200;
      end else if (s >= 8'd100) begin
         h = 4'd1;
         r = s - 8'd100;
      end else begin
         h = 4'd0;
         r = s;
      end
      t   = 4'd0;
      sub = 8'd0;
      for (int i = 9; i >= 1; i--) begin
         if (t == 4'd0 && r >= 8'(i * 10)) begin
            t   = 4'(i);
            sub = 8'(i * 10);
         end
      end
      return {4'h3, h, 4'h3, t, 4'h3, 4'(r - sub)};
   endfunction

`ifdef FIX_ENC_SEQNUM_EN
   function automatic logic [23:0] bcd_inc(input logic [23:0] v);
      logic [23:0] o;
      logic        c;
      logic [3:0]  d;
      o = v;
      c = 1'b1;
      for (int i = 0; i < 6; i++) begin
         d = v[i*4 +: 4];
         if (c) begin
            if (d == 4'd9) begin
               d = 4'd0;
            end else begin
               d = d + 4'd1;
               c = 1'b0;
            end
         end
         o[i*4 +: 4] = d;
      end
      return o;
   endfunction
`endif

   assign accept    = req_valid && req_ready;
   assign beat      = (state_q != S_IDLE) && tx_ready;
   assign req_ready = ready_q && (state_q == S_IDLE);
   assign sum_fin   = sum_q + tx_data;

   // Tag characters, value length and right-aligned value of the current body field.
   always_comb begin
      type_char = "F";
      tag_hi    = "3";
      tag_lo    = "5";
      vlen      = 4'd1;
      fval      = '0;
      if (typ_q == TYPE_D)
         type_char = "D";
      else if (typ_q == TYPE_G)
         type_char = "G";
      case (fld_q)
         FLD_35: fval = {56'd0, type_char};
`ifdef FIX_ENC_SEQNUM_EN
         FLD_34: begin
            tag_lo = "4";
            vlen   = 4'd6;
            fval   = {16'd0, 4'h3, seq_q[23:20], 4'h3, seq_q[19:16], 4'h3, seq_q[15:12],
                      4'h3, seq_q[11:8], 4'h3, seq_q[7:4], 4'h3, seq_q[3:0]};
         end
`endif
         FLD_11: begin tag_hi = "1"; tag_lo = "1"; vlen = 4'd4; fval = {32'd0, id_q};   end
         FLD_41: begin tag_hi = "4"; tag_lo = "1"; vlen = 4'd4; fval = {32'd0, orig_q}; end
         FLD_55: begin tag_hi = "5"; tag_lo = "5"; vlen = 4'd6; fval = {16'd0, sym_q};  end
         FLD_54: begin tag_hi = "5"; tag_lo = "4"; vlen = 4'd1; fval = {56'd0, side_q}; end
         FLD_44: begin tag_hi = "4"; tag_lo = "4"; vlen = 4'd8; fval = px_q;            end
         FLD_38: begin tag_hi = "3"; tag_lo = "8"; vlen = 4'd8; fval = qty_q;           end
         default: ;
      endcase
   end

   // Lowest present field above the current one; none means the body is done.
   always_comb begin
      nxt_found = 1'b0;
      nxt_fld   = fld_q;
      for (int i = 7; i >= 1; i--) begin
         if (3'(i) > fld_q && fld_present(3'(i), typ_q)) begin
            nxt_found = 1'b1;
            nxt_fld   = 3'(i);
         end
      end
   end

   // Body field layout: tag(2) '=' value(vlen) SOH.
   assign fld_last = (cnt_q == vlen + 4'd3);
   assign vidx     = cnt_q - 4'd3;
   assign vsh      = 3'(vlen - 4'd1 - vidx);
   assign hsh      = 4'd9 - cnt_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      fld_d    = fld_q;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      tx_sop   = 1'b0;
      tx_eop   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept && req_type != 2'b00) begin
               state_d = S_HDR;
               cnt_d   = 4'd0;
            end
         end
         S_HDR: begin
            tx_valid = 1'b1;
            tx_data  = HDR_STR[{hsh, 3'b000} +: 8];
            tx_sop   = (cnt_q == 4'd0);
            if (beat) begin
               if (cnt_q == 4'd9) begin
                  state_d = S_BLEN;
                  cnt_d   = 4'd0;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         S_BLEN: begin
            tx_valid = 1'b1;
            case (cnt_q)
               4'd0:    tx_data = "9";
               4'd1:    tx_data = "=";
               4'd2:    tx_data = blen_q[15:8];
               4'd3:    tx_data = blen_q[7:0];
               default: tx_data = SOH_CHAR;
            endcase
            if (beat) begin
               if (cnt_q == 4'd4) begin
                  state_d = S_BODY;
                  cnt_d   = 4'd0;
                  fld_d   = FLD_35;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         S_BODY: begin
            tx_valid = 1'b1;
            if (cnt_q == 4'd0)
               tx_data = tag_hi;
            else if (cnt_q == 4'd1)
               tx_data = tag_lo;
            else if (cnt_q == 4'd2)
               tx_data = "=";
            else if (fld_last)
               tx_data = SOH_CHAR;
            else
               tx_data = fval[{vsh, 3'b000} +: 8];
            if (beat) begin
               if (fld_last) begin
                  cnt_d = 4'd0;
                  if (nxt_found)
                     fld_d = nxt_fld;
                  else
                     state_d = S_CKSUM;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         S_CKSUM: begin
            tx_valid = 1'b1;
            tx_eop   = (cnt_q == 4'd6);
            case (cnt_q)
               4'd0:    tx_data = "1";
               4'd1:    tx_data = "0";
               4'd2:    tx_data = "=";
               4'd3:    tx_data = ck_q[23:16];
               4'd4:    tx_data = ck_q[15:8];
               4'd5:    tx_data = ck_q[7:0];
               default: tx_data = SOH_CHAR;
            endcase
            if (beat) begin
               if (cnt_q == 4'd6) begin
                  state_d = S_IDLE;
                  cnt_d   = 4'd0;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         fld_q   <= FLD_35;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fld_q   <= fld_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_q <= 1'b0;
         req_err <= 1'b0;
         typ_q   <= 2'b00;
         id_q    <= '0;
         orig_q  <= '0;
         sym_q   <= '0;
         side_q  <= '0;
         px_q    <= '0;
         qty_q   <= '0;
         blen_q  <= '0;
         sum_q   <= '0;
         ck_q    <= '0;
      end else begin
         ready_q <= 1'b1;
         req_err <= accept && (req_type == 2'b00);
         if (accept) begin
            typ_q  <= req_type;
            id_q   <= cl_ord_id;
            orig_q <= orig_cl_ord_id;
            sym_q  <= symbol;
            side_q <= side;
            px_q   <= price;
            qty_q  <= quantity;
            sum_q  <= 8'd0;
            if (req_type == TYPE_D)
               blen_q <= BLEN_D;
            else if (req_type == TYPE_G)
               blen_q <= BLEN_G;
            else
               blen_q <= BLEN_F;
         end else if (beat && state_q != S_CKSUM) begin
            sum_q <= sum_fin;
         end
         // The final body SOH is included by converting the sum as it stands after this beat.
         if (state_q == S_BODY && state_d == S_CKSUM)
            ck_q <= to_ascii3(sum_fin);
      end
   end

`ifdef FIX_ENC_SEQNUM_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         seq_q <= 24'h000001;
      else if (state_q == S_CKSUM && beat && cnt_q == 4'd6)
         seq_q <= bcd_inc(seq_q);
   end
`endif

endmodule

// File: tb/tb_fix_order_encoder.sv
// tb/tb_fix_order_encoder.sv - self-checking bench for fix_order_encoder against a byte-queue message model
module tb_fix_order_encoder;

   localparam logic [7:0] SOH = 8'h01;
`ifdef FIX_ENC_SEQNUM_EN
   localparam int    LEN_D = 84, LEN_G = 92, LEN_F = 68;
   localparam string BL_D = "9=62", BL_G = "9=70", BL_F = "9=46";
`else
   localparam int    LEN_D = 74, LEN_G = 82, LEN_F = 58;
   localparam string BL_D = "9=52", BL_G = "9=60", BL_F = "9=36";
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [1:0]  req_type;
   logic [31:0] cl_ord_id, orig_cl_ord_id;
   logic [47:0] symbol;
   logic [7:0]  side;
   logic [63:0] price, quantity;
   logic [7:0]  tx_data;
   logic        tx_valid, tx_ready, tx_sop, tx_eop, req_err;

   int          n_pass, n_total;
   int          beat_cnt;
   int          model_seq;
   bit          stall_mode;
   byte unsigned msg[$];
   logic [9:0]  exp_q[$];

   always #5 clk = ~clk;

   fix_order_encoder dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
      .cl_ord_id(cl_ord_id), .orig_cl_ord_id(orig_cl_ord_id), .symbol(symbol),
      .side(side), .price(price), .quantity(quantity),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_sop(tx_sop), .tx_eop(tx_eop), .req_err(req_err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic put_str(input string s);
      for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
   endtask

   task automatic put_val(input logic [63:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) msg.push_back(v[i*8 +: 8]);
      msg.push_back(SOH);
   endtask

   function automatic bit str_at(input int pos, input string s);
      for (int i = 0; i < s.len(); i++)
         if (pos + i >= msg.size() || msg[pos+i] != s[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int find_tag(input string s);
      for (int p = 1; p < msg.size(); p++)
         if (msg[p-1] == SOH && str_at(p, s)) return p;
      return -1;
   endfunction

   // Message model: assemble the body, count it for tag 9, sum everything for tag 10.
   task automatic build_msg(input logic [1:0] t, input logic [31:0] id, input logic [31:0] orig,
                            input logic [47:0] sym, input logic [7:0] sd,
                            input logic [63:0] px, input logic [63:0] qty);
      byte unsigned body[$];
      int sum;
      msg.delete();
      put_str("35=");
      put_val((t == 2'b01) ? 64'h44 : (t == 2'b10) ? 64'h47 : 64'h46, 1);
`ifdef FIX_ENC_SEQNUM_EN
      put_str("34=");
      put_str($sformatf("%06d", model_seq));
      msg.push_back(SOH);
      model_seq = (model_seq + 1) % 1000000;
`endif
      put_str("11="); put_val({32'd0, id}, 4);
      if (t != 2'b01) begin put_str("41="); put_val({32'd0, orig}, 4); end
      put_str("55="); put_val({16'd0, sym}, 6);
      put_str("54="); put_val({56'd0, sd}, 1);
      if (t != 2'b11) begin
         put_str("44="); put_val(px, 8);
         put_str("38="); put_val(qty, 8);
      end
      body = msg;
      msg.delete();
      put_str("8=FIX.4.2"); msg.push_back(SOH);
      put_str("9="); put_str($sformatf("%02d", body.size())); msg.push_back(SOH);
      foreach (body[i]) msg.push_back(body[i]);
      sum = 0;
      foreach (msg[i]) sum += msg[i];
      put_str("10="); put_str($sformatf("%03d", sum % 256)); msg.push_back(SOH);
   endtask

   task automatic send_req(input logic [1:0] t, input logic [31:0] id, input logic [31:0] orig,
                           input logic [47:0] sym, input logic [7:0] sd,
                           input logic [63:0] px, input logic [63:0] qty);
      int n = 0;
      while (!req_ready && n < 3000) begin @(posedge clk); #1; n++; end
      if (!req_ready) begin check("req_ready_timeout", req_ready, 1); return; end
      if (t != 2'b00) begin
         build_msg(t, id, orig, sym, sd, px, qty);
         foreach (msg[i]) exp_q.push_back({i == 0, i == msg.size() - 1, msg[i]});
      end
      req_valid = 1'b1; req_type = t; cl_ord_id = id; orig_cl_ord_id = orig;
      symbol = sym; side = sd; price = px; quantity = qty;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("ready_after_accept", req_ready, (t == 2'b00));
      check("err_after_accept", req_err, (t == 2'b00));
      check("valid_after_accept", tx_valid, (t != 2'b00));
      check("sop_after_accept", tx_sop, (t != 2'b00));
   endtask

   task automatic wait_done();
      int n = 0;
      while ((exp_q.size() != 0 || !req_ready) && n < 3000) begin @(posedge clk); #1; n++; end
      check("msg_done", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      exp_q.delete();
      model_seq = 1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("ready_in_release_cycle", req_ready, 0);
      @(posedge clk); #1;
      check("ready_after_release", req_ready, 1);
   endtask

   task automatic monitor();
      logic [9:0] prev, cur, e;
      bit prev_stall = 0, prev_eop = 0, in_msg = 0;
      forever begin
         @(negedge clk);
         if (rst) begin prev_stall = 0; prev_eop = 0; in_msg = 0; continue; end
         cur = {tx_sop, tx_eop, tx_data};
         if (prev_eop) check("ready_after_eop", req_ready, 1);
         prev_eop = 0;
         if (in_msg) check("no_bubble", tx_valid, 1);
         if (prev_stall) check("stall_hold", cur, prev);
         prev_stall = tx_valid && !tx_ready;
         prev = cur;
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_beat", tx_valid, 0);
            end else begin
               e = exp_q.pop_front();
               check("beat", cur, e);
               beat_cnt++;
               prev_eop = e[8];
               in_msg = !e[8];
            end
         end
      end
   endtask

   task automatic ready_drv();
      forever begin
         @(posedge clk); #1;
         tx_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   endtask

   function automatic logic [63:0] rand_ascii();
      logic [63:0] v;
      for (int i = 0; i < 8; i++) v[i*8 +: 8] = 8'($urandom_range(32, 126));
      return v;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [63:0] r1, r2, r3, r4, r5;
      logic [1:0]  t;
      int          base, n;
      n_pass = 0; n_total = 0; beat_cnt = 0; model_seq = 1; stall_mode = 0;
      rst = 1'b1; req_valid = 1'b0; req_type = 2'b00; tx_ready = 1'b1;
      cl_ord_id = '0; orig_cl_ord_id = '0; symbol = '0; side = '0; price = '0; quantity = '0;
      fork
         monitor();
         ready_drv();
      join_none
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_sop", tx_sop, 0);
      check("rst_tx_eop", tx_eop, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_req_err", req_err, 0);
      check("rst_req_ready", req_ready, 0);
      rst = 1'b0;
      check("ready_in_release_cycle", req_ready, 0);
      @(posedge clk); #1;
      check("ready_after_release", req_ready, 1);

      // D, no backpressure
      send_req(2'b01, "1234", "0000", "AAPL  ", "1", "00150.25", "00000100");
      check("pin_D_len", msg.size(), LEN_D);
      check("pin_D_blen", str_at(10, BL_D), 1);
      check("pin_D_blen_soh", msg[14], SOH);
      check("pin_D_no41", find_tag("41=") < 0, 1);
      check("pin_D_hdr", str_at(0, "8=FIX.4.2"), 1);
      wait_done();

      // F
      send_req(2'b11, "1235", "1234", "AAPL  ", "2", "99999999", "99999999");
      check("pin_F_len", msg.size(), LEN_F);
      check("pin_F_blen", str_at(10, BL_F), 1);
      check("pin_F_no44", find_tag("44=") < 0, 1);
      check("pin_F_no38", find_tag("38=") < 0, 1);
      check("pin_F_41_before_55", (find_tag("41=") > 0) && (find_tag("41=") < find_tag("55=")), 1);
      wait_done();

      // G without and with 50% backpressure
      send_req(2'b10, "5678", "1234", "MSFT  ", "1", "00321.50", "00000250");
      check("pin_G_len", msg.size(), LEN_G);
      check("pin_G_blen", str_at(10, BL_G), 1);
      wait_done();
      stall_mode = 1;
      send_req(2'b10, "5678", "1234", "MSFT  ", "1", "00321.50", "00000250");
      wait_done();
      stall_mode = 0;
      @(posedge clk); #1;

      // illegal type, then a normal D
      send_req(2'b00, "9999", "9999", "XXXXXX", "1", "00000001", "00000001");
      @(posedge clk); #1;
      check("err_one_pulse", req_err, 0);
      check("illegal_no_valid", tx_valid, 0);
      check("illegal_ready", req_ready, 1);
      send_req(2'b01, "4321", "0000", "IBM   ", "2", "00010.00", "00000005");
      wait_done();

      // async reset in the middle of a D message
      base = beat_cnt;
      send_req(2'b01, "7777", "0000", "GOOG  ", "1", "01234.56", "00000010");
      n = 0;
      while (beat_cnt < base + 30 && n < 500) begin @(negedge clk); #1; n++; end
      check("reach_byte_30", beat_cnt >= base + 30, 1);
      rst = 1'b1;
      #1;
      check("rst_kills_valid", tx_valid, 0);
      exp_q.delete();
      model_seq = 1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("ready_in_release_cycle", req_ready, 0);
      @(posedge clk); #1;
      check("ready_after_release", req_ready, 1);
      send_req(2'b01, "7778", "0000", "GOOG  ", "1", "01234.56", "00000010");
      wait_done();

`ifdef FIX_ENC_SEQNUM_EN
      do_reset();
      for (int k = 1; k <= 3; k++) begin
         send_req(2'b01, "1000", "0000", "AAPL  ", "1", "00150.25", "00000100");
         check("pin_seq_tag", str_at(20, $sformatf("34=%06d", k)), 1);
         check("pin_seq_blen", str_at(10, "9=62"), 1);
      end
      wait_done();
`endif

      // randomized requests, types and backpressure
      for (int k = 0; k < 10; k++) begin
         r1 = rand_ascii(); r2 = rand_ascii(); r3 = rand_ascii(); r4 = rand_ascii(); r5 = rand_ascii();
         t = 2'($urandom_range(0, 3));
         stall_mode = 1'($urandom_range(0, 1));
         send_req(t, r1[31:0], r2[31:0], r3[47:0], r4[7:0], r4, r5);
         if (t == 2'b00) begin
            @(posedge clk); #1;
            check("rand_err_pulse", req_err, 0);
         end else begin
            wait_done();
         end
      end
      stall_mode = 0;
      repeat (5) @(posedge clk);
      #1;
      check("end_queue_empty", exp_q.size(), 0);
      check("end_idle", req_ready, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
